alu_muldiv_ctrl: RTL

Next-generation ALU control for the RV32 core. It keeps the combinational ALUOp/funct decode and adds RV32M support through a multi-cycle sequencer: a pipelined multiplier wrapper and an iterative radix-2 divider, both parametrised in XLEN. It sits in the EX stage beside the ALU. It stalls the pipeline while an M-extension op is in flight and returns the M result on its own bus.

---
 rtl/alu_muldiv_ctrl_pkg.sv | 118 +++++++++++
 rtl/alu_muldiv_ctrl_serial_divider.sv | 114 +++++++++++
 rtl/alu_muldiv_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_ctrl_pkg
// Purpose  : Shared ALU operation codes, funct/opcode constants, sequencer
//            state encoding and the combinational ALU decode function.
// Revision : 1.0 - initial release with RV32M codes
// ============================================================================
package alu_muldiv_ctrl_pkg;

  // ALU operation codes driven onto the ALU control bus
  localparam logic [4:0] OPNULL   = 5'd0;
  localparam logic [4:0] OPADD    = 5'd1;
  localparam logic [4:0] OPSUB    = 5'd2;
  localparam logic [4:0] OPSLL    = 5'd3;
  localparam logic [4:0] OPSLT    = 5'd4;
  localparam logic [4:0] OPSLTU   = 5'd5;
  localparam logic [4:0] OPXOR    = 5'd6;
  localparam logic [4:0] OPSRL    = 5'd7;
  localparam logic [4:0] OPSRA    = 5'd8;
  localparam logic [4:0] OPOR     = 5'd9;
  localparam logic [4:0] OPAND    = 5'd10;
  localparam logic [4:0] OPLUI    = 5'd11;
  localparam logic [4:0] OPMUL    = 5'd16;
  localparam logic [4:0] OPMULH   = 5'd17;
  localparam logic [4:0] OPMULHSU = 5'd18;
  localparam logic [4:0] OPMULHU  = 5'd19;
  localparam logic [4:0] OPDIV    = 5'd20;
  localparam logic [4:0] OPDIVU   = 5'd21;
  localparam logic [4:0] OPREM    = 5'd22;
  localparam logic [4:0] OPREMU   = 5'd23;

  // ALUOp encodings from main control
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_LUI    = 2'b11;

  // funct3 of R/I-type arithmetic
  localparam logic [2:0] FUN3ADD  = 3'b000;
  localparam logic [2:0] FUN3SLL  = 3'b001;
  localparam logic [2:0] FUN3SLT  = 3'b010;
  localparam logic [2:0] FUN3SLTU = 3'b011;
  localparam logic [2:0] FUN3XOR  = 3'b100;
  localparam logic [2:0] FUN3SR   = 3'b101;
  localparam logic [2:0] FUN3OR   = 3'b110;
  localparam logic [2:0] FUN3AND  = 3'b111;

  // funct3 of branches
  localparam logic [2:0] FUN3BEQ  = 3'b000;
  localparam logic [2:0] FUN3BNE  = 3'b001;
  localparam logic [2:0] FUN3BLT  = 3'b100;
  localparam logic [2:0] FUN3BGE  = 3'b101;
  localparam logic [2:0] FUN3BLTU = 3'b110;
  localparam logic [2:0] FUN3BGEU = 3'b111;

  localparam logic [6:0] FUN7ZERO   = 7'b0000000;
  localparam logic [6:0] FUN7ALT    = 7'b0100000;
  localparam logic [6:0] FUN7MULDIV = 7'b0000001;

  localparam logic [6:0] OPCODE_OP = 7'b0110011;

  // M-op sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Combinational ALUOp/funct decode to an ALU operation code
  function automatic logic [4:0] alu_decode(
    input logic [1:0] aluop,
    input logic [6:0] opcode,
    input logic [6:0] funct7,
    input logic [2:0] funct3,
    input logic       m_ext
  );
    logic [4:0] op;
    op = OPNULL;
    case (aluop)
      ALUOP_ADD: op = OPADD;
      ALUOP_LUI: op = OPLUI;
      ALUOP_BRANCH: begin
        case (funct3)
          FUN3BEQ, FUN3BNE:   op = OPSUB;
          FUN3BLT, FUN3BGE:   op = OPSLT;
          FUN3BLTU, FUN3BGEU: op = OPSLTU;
          default:            op = OPNULL;
        endcase
      end
      default: begin
        if (funct7 == FUN7MULDIV) begin
          // M-extension ops occupy a contiguous code block indexed by funct3
          op = m_ext ? (OPMUL + {2'b00, funct3}) : OPNULL;
        end else begin
          case (funct3)
            // I-type ADDI reuses funct7 bits as immediate, so only OP may subtract
            FUN3ADD:  op = (opcode == OPCODE_OP && funct7 == FUN7ALT) ? OPSUB : OPADD;
            FUN3SLL:  op = OPSLL;
            FUN3SLT:  op = OPSLT;
            FUN3SLTU: op = OPSLTU;
            FUN3XOR:  op = OPXOR;
            FUN3SR: begin
              if (funct7 == FUN7ALT)       op = OPSRA;
              else if (funct7 == FUN7ZERO) op = OPSRL;
              else                         op = OPNULL;
            end
            FUN3OR:   op = OPOR;
            default:  op = OPAND;
          endcase
        end
      end
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_ctrl_serial_divider.sv
`default_nettype none
// ============================================================================
// Module   : serial_divider
// Purpose  : Radix-2 restoring divider on operand magnitudes, one quotient
//            bit per cycle. Detects divide-by-zero and signed overflow at
//            start and loads the architectural results immediately.
// Revision : 1.0 - initial release
// ============================================================================
module serial_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            special,
  output logic            last,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_COUNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            busy;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvsr;
  logic            neg_q;
  logic            neg_r;

  logic            div_zero;
  logic            overflow;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Start-time operand classification and magnitudes, plus one restoring step
  always_comb begin
    div_zero = (divisor == '0);
    overflow = is_signed && (dividend == MOST_NEG) && (divisor == '1);
    special  = div_zero || overflow;
    sign_a   = is_signed && dividend[XLEN-1];
    sign_b   = is_signed && divisor[XLEN-1];
    mag_a    = sign_a ? (~dividend + 1'b1) : dividend;
    mag_b    = sign_b ? (~divisor + 1'b1) : divisor;
    shifted  = {rem, quot[XLEN-1]};
    diff     = shifted - {1'b0, dvsr};
    last     = busy && (count == LAST_COUNT);
  end

  // Iteration registers: special cases load final values, otherwise shift-subtract
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      count <= '0;
      quot  <= '0;
      rem   <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (start) begin
      count <= '0;
      if (div_zero) begin
        quot  <= '1;
        rem   <= dividend;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
        busy  <= 1'b0;
      end else if (overflow) begin
        quot  <= dividend;
        rem   <= '0;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
        busy  <= 1'b0;
      end else begin
        quot  <= mag_a;
        rem   <= '0;
        dvsr  <= mag_b;
        neg_q <= sign_a ^ sign_b;
        neg_r <= sign_a;
        busy  <= 1'b1;
      end
    end else if (busy) begin
      if (!diff[XLEN]) begin
        rem  <= diff[XLEN-1:0];
        quot <= {quot[XLEN-2:0], 1'b1};
      end else begin
        rem  <= shifted[XLEN-1:0];
        quot <= {quot[XLEN-2:0], 1'b0};
      end
      count <= count + CW'(1);
      if (last) busy <= 1'b0;
    end
  end

  // Restore operand signs on the registered magnitudes
  always_comb begin
    quotient  = neg_q ? (~quot + 1'b1) : quot;
    remainder = neg_r ? (~rem + 1'b1) : rem;
  end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_ctrl
// Purpose  : EX-stage ALU control with RV32M sequencer. Decodes ALU ops
//            combinationally and runs MUL*/DIV*/REM* over several cycles,
//            stalling the pipeline and returning the result on its own bus.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_ctrl
  import alu_muldiv_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int M_EXT      = 1
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic            iFlush,
  input  logic [6:0]      iOpcode,
  input  logic [6:0]      iFunct7,
  input  logic [2:0]      iFunct3,
  input  logic [1:0]      iALUOp,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic [4:0]      oControlSignal,
  output logic            oIsMulDiv,
  output logic            oStall,
  output logic            oDone,
  output logic [XLEN-1:0] oResult
);

  localparam int MCW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [MCW-1:0] MUL_LAST = MCW'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              div_start;
  logic              div_special;
  logic              div_last;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [2:0]        funct3_q;
  logic [MCW-1:0]    mul_cnt;
  logic [XLEN-1:0]   result_q;
  logic [XLEN-1:0]   fresh;
  logic [2*XLEN-1:0] product;
  logic              a_signed;
  logic              b_signed;

  // ALU operation decode and M-op detection
  always_comb begin
    oControlSignal = alu_decode(iALUOp, iOpcode, iFunct7, iFunct3, (M_EXT != 0));
    oIsMulDiv      = (M_EXT != 0) && (iALUOp == ALUOP_FUNCT) && (iFunct7 == FUN7MULDIV);
    accept         = (state == ST_IDLE) && iStart && oIsMulDiv && !iFlush;
    div_start      = accept && iFunct3[2];
  end

  serial_divider #(
    .XLEN(XLEN)
  ) u_div (
    .clk       (iCLK),
    .rst       (iRST),
    .flush     (iFlush),
    .start     (div_start),
    .is_signed (!iFunct3[0]),
    .dividend  (iA),
    .divisor   (iB),
    .special   (div_special),
    .last      (div_last),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Full-width product on latched operands; MULH signs both, MULHSU only rs1
  always_comb begin
    a_signed = op_a[XLEN-1] && (funct3_q[1:0] == 2'b01 || funct3_q[1:0] == 2'b10);
    b_signed = op_b[XLEN-1] && (funct3_q[1:0] == 2'b01);
    product  = {{XLEN{a_signed}}, op_a} * {{XLEN{b_signed}}, op_b};
    if (funct3_q[2])
      fresh = funct3_q[1] ? remainder : quotient;
    else
      fresh = (funct3_q[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge iCLK) begin
    if (iRST) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state = state;
    oStall     = 1'b0;
    oDone      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          oStall = 1'b1;
          if (iFunct3[2])
            next_state = div_special ? ST_DONE : ST_DIV;
          else
            next_state = (MUL_CYCLES == 1) ? ST_DONE : ST_MUL;
        end
      end
      ST_MUL: begin
        oStall = 1'b1;
        if (iFlush)                    next_state = ST_IDLE;
        else if (mul_cnt == MUL_LAST)  next_state = ST_DONE;
      end
      ST_DIV: begin
        oStall = 1'b1;
        if (iFlush)        next_state = ST_IDLE;
        else if (div_last) next_state = ST_DONE;
      end
      default: begin
        // iStart here belongs to the instruction just completed
        next_state = ST_IDLE;
        oDone      = !iFlush;
      end
    endcase
    oResult = oDone ? fresh : result_q;
  end

  // Operand latch, multiply cycle counter and held result
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      op_a     <= '0;
      op_b     <= '0;
      funct3_q <= '0;
      mul_cnt  <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_a     <= iA;
        op_b     <= iB;
        funct3_q <= iFunct3;
        mul_cnt  <= '0;
      end else if (state == ST_MUL) begin
        mul_cnt <= mul_cnt + MCW'(1);
      end
      if (oDone) result_q <= fresh;
    end
  end

endmodule
`default_nettype wire
